// File: rtl/exe_alu_arbiter.sv
// exe_alu_arbiter
//
// Shares one combinational execute-stage ALU between the main pipeline issue
// port (P) and a coprocessor/helper port (C). The granted requester drives the
// ALU inputs. The ALU result is captured into a single-entry response slot that
// is tagged with its owner and returned on that owner's response channel.
//
// Handshake semantics: a request transfers on a rising clk edge where
// x_valid && x_ready. A response transfers on an edge where x_rvalid && x_rready.
// x_ready may depend on x_valid, but x_valid must never depend on x_ready.
// While x_rvalid && !x_rready, x_rdata is held stable.
//
// Arbitration: P has priority. A saturating starvation counter counts the
// grants P wins while C is waiting. Once the counter reaches STARVE_LIMIT,
// C wins the next free slot.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   p_valid/p_ready          P request handshake; p_a, p_b, p_op are the request
//   p_rvalid/p_rready        P response handshake; p_rdata is the result
//   c_*                      the same set of signals for the C port
//   alu_a, alu_b, alu_op     ALU inputs, driven combinationally from the grant
//   alu_y                    ALU result, sampled only on an accepting edge
//   c_starved                high while the starve counter equals STARVE_LIMIT
module exe_alu_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_valid,
  output logic                  p_ready,
  input  logic [DATA_WIDTH-1:0] p_a,
  input  logic [DATA_WIDTH-1:0] p_b,
  input  logic [4:0]            p_op,
  output logic                  p_rvalid,
  input  logic                  p_rready,
  output logic [DATA_WIDTH-1:0] p_rdata,
  input  logic                  c_valid,
  output logic                  c_ready,
  input  logic [DATA_WIDTH-1:0] c_a,
  input  logic [DATA_WIDTH-1:0] c_b,
  input  logic [4:0]            c_op,
  output logic                  c_rvalid,
  input  logic                  c_rready,
  output logic [DATA_WIDTH-1:0] c_rdata,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_y,
  output logic                  c_starved
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P    = 2'd1,
    GNT_C    = 2'd2
  } grant_t;

  logic                  res_valid;
  logic                  res_owner;  // 0 = P, 1 = C
  logic [DATA_WIDTH-1:0] res_data;
  logic [SW-1:0]         starve;

  logic   consumed;
  logic   can_accept;
  logic   p_acc;
  logic   c_acc;
  grant_t grant;

  // When the held result is consumed on this edge, the slot is already free,
  // so a new request can be granted in the same cycle.
  assign consumed   = res_valid && (res_owner ? c_rready : p_rready);
  assign can_accept = !res_valid || consumed;

  always_comb begin
    grant = GNT_NONE;
    if (can_accept) begin
      if (c_valid && (!p_valid || starve == LIMIT)) begin
        grant = GNT_C;
      end else if (p_valid) begin
        grant = GNT_P;
      end
    end
  end

  assign p_ready = (grant == GNT_P);
  assign c_ready = (grant == GNT_C);
  assign p_acc   = p_valid && p_ready;
  assign c_acc   = c_valid && c_ready;

  // With no grant, the ALU inputs are parked at zero so that the ALU does not
  // toggle on requests that were not granted.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    case (grant)
      GNT_P: begin
        alu_a  = p_a;
        alu_b  = p_b;
        alu_op = p_op;
      end
      GNT_C: begin
        alu_a  = c_a;
        alu_b  = c_b;
        alu_op = c_op;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_owner <= 1'b0;
      res_data  <= '0;
    end else if (p_acc || c_acc) begin
      res_valid <= 1'b1;
      res_owner <= c_acc;
      res_data  <= alu_y;
    end else if (consumed) begin
      res_valid <= 1'b0;
    end
  end

  // The counter clears whenever C is not waiting or C wins. It counts only
  // the grants P wins while C waits. It holds while the slot is blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (c_acc || !c_valid) begin
      starve <= '0;
    end else if (p_acc && starve != LIMIT) begin
      starve <= starve + SW'(1);
    end
  end

  assign p_rvalid  = res_valid && !res_owner;
  assign c_rvalid  = res_valid && res_owner;
  assign p_rdata   = p_rvalid ? res_data : '0;
  assign c_rdata   = c_rvalid ? res_data : '0;
  assign c_starved = (starve == LIMIT);

endmodule

// File: tb/tb_exe_alu_arbiter.sv
// tb_exe_alu_arbiter
//
// Bench for exe_alu_arbiter. A behavioural ALU drives alu_y. Expected results
// are pushed when a request is accepted. They are popped when the owner
// consumes its response.
module tb_exe_alu_arbiter;

  localparam int DW = 64;
  localparam int SL = 4;

  logic          clk;
  logic          rst;
  logic          p_valid, p_ready, p_rvalid, p_rready;
  logic [DW-1:0] p_a, p_b, p_rdata;
  logic [4:0]    p_op;
  logic          c_valid, c_ready, c_rvalid, c_rready;
  logic [DW-1:0] c_a, c_b, c_rdata;
  logic [4:0]    c_op;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic [4:0]    alu_op;
  logic          c_starved;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] p_exp_q[$];
  logic [DW-1:0] c_exp_q[$];

  // Reference arbiter state, used only during the random phase.
  bit   model_on = 0;
  logic m_valid  = 1'b0;
  logic m_owner  = 1'b0;
  int   m_starve = 0;

  exe_alu_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_ready(p_ready), .p_a(p_a), .p_b(p_b), .p_op(p_op),
    .p_rvalid(p_rvalid), .p_rready(p_rready), .p_rdata(p_rdata),
    .c_valid(c_valid), .c_ready(c_ready), .c_a(c_a), .c_b(c_b), .c_op(c_op),
    .c_rvalid(c_rvalid), .c_rready(c_rready), .c_rdata(c_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .c_starved(c_starved)
  );

  // ALU opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  function automatic logic [DW-1:0] ref_alu(input logic [4:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  always_comb alu_y = ref_alu(alu_op, alu_a, alu_b);

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. The task first lets the driven inputs settle. It then
  // does the scoreboard and model bookkeeping, advances past the edge, and
  // returns 1 time unit after the edge.
  task automatic cycle();
    logic free, ep, ec;
    #1;
    if (p_rvalid && p_rready) begin
      if (p_exp_q.size() == 0) check("p_unexpected_rsp", DW'(1), DW'(0));
      else check("p_rdata_sb", p_rdata, p_exp_q.pop_front());
    end
    if (c_rvalid && c_rready) begin
      if (c_exp_q.size() == 0) check("c_unexpected_rsp", DW'(1), DW'(0));
      else check("c_rdata_sb", c_rdata, c_exp_q.pop_front());
    end
    if (!p_rvalid) check("p_rdata_zero", p_rdata, '0);
    if (!c_rvalid) check("c_rdata_zero", c_rdata, '0);
    check("ready_exclusive", DW'(p_ready & c_ready), '0);
    if (model_on) begin
      free = !m_valid || (m_owner ? c_rready : p_rready);
      ec   = free && c_valid && (!p_valid || m_starve == SL);
      ep   = free && p_valid && !ec;
      check("m_p_ready", DW'(p_ready), DW'(ep));
      check("m_c_ready", DW'(c_ready), DW'(ec));
      check("m_p_rvalid", DW'(p_rvalid), DW'(m_valid && !m_owner));
      check("m_c_rvalid", DW'(c_rvalid), DW'(m_valid && m_owner));
      check("m_c_starved", DW'(c_starved), DW'(m_starve == SL));
      if (ep || ec) begin
        m_valid = 1'b1;
        m_owner = ec;
      end else if (free) begin
        m_valid = 1'b0;
      end
      if (ec || !c_valid) m_starve = 0;
      else if (ep && m_starve < SL) m_starve++;
    end
    if (!rst) begin
      if (p_valid && p_ready) p_exp_q.push_back(ref_alu(p_op, p_a, p_b));
      if (c_valid && c_ready) c_exp_q.push_back(ref_alu(c_op, c_a, c_b));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p(input logic v, input logic [4:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    p_valid = v; p_op = op; p_a = a; p_b = b;
  endtask

  task automatic drive_c(input logic v, input logic [4:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    c_valid = v; c_op = op; c_a = a; c_b = b;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    rst = 1'b1;
    drive_p(1'b0, 5'd0, '0, '0);
    drive_c(1'b0, 5'd0, '0, '0);
    p_rready = 1'b1;
    c_rready = 1'b1;

    // Reset state and idle
    @(posedge clk); #1;
    check("rst_p_rvalid", DW'(p_rvalid), '0);
    check("rst_c_rvalid", DW'(c_rvalid), '0);
    check("rst_p_rdata", p_rdata, '0);
    check("rst_c_rdata", c_rdata, '0);
    check("rst_c_starved", DW'(c_starved), '0);
    rst = 1'b0;
    #1;
    check("idle_alu_a", alu_a, '0);
    check("idle_alu_b", alu_b, '0);
    check("idle_alu_op", DW'(alu_op), '0);
    check("idle_p_ready", DW'(p_ready), '0);
    check("idle_c_ready", DW'(c_ready), '0);
    cycle();

    // Single request: ADD 5 + 3
    drive_p(1'b1, 5'd0, 64'd5, 64'd3);
    #1;
    check("single_p_ready", DW'(p_ready), DW'(1));
    check("single_c_ready", DW'(c_ready), '0);
    check("single_alu_a", alu_a, 64'd5);
    check("single_alu_b", alu_b, 64'd3);
    cycle();
    drive_p(1'b0, 5'd0, '0, '0);
    #1;
    check("single_p_rvalid", DW'(p_rvalid), DW'(1));
    check("single_c_rvalid", DW'(c_rvalid), '0);
    check("single_p_rdata", p_rdata, 64'd8);
    cycle();
    check("single_drained", DW'(p_rvalid), '0);

    // Starvation: both ports request every cycle, and C is forced through in cycle 4
    for (int k = 0; k < 6; k++) begin
      drive_p(1'b1, 5'($urandom_range(0, 4)), rand_word(), rand_word());
      drive_c(1'b1, 5'($urandom_range(0, 4)), rand_word(), rand_word());
      #1;
      check($sformatf("starve_p_ready_%0d", k), DW'(p_ready), DW'(k != 4));
      check($sformatf("starve_c_ready_%0d", k), DW'(c_ready), DW'(k == 4));
      check($sformatf("starve_flag_%0d", k), DW'(c_starved), DW'(k == 4));
      cycle();
    end
    drive_p(1'b0, 5'd0, '0, '0);
    drive_c(1'b0, 5'd0, '0, '0);
    cycle();

    // Backpressure: SUB 10 - 4 is held while P stalls, and C waits behind it
    p_rready = 1'b0;
    drive_p(1'b1, 5'd1, 64'd10, 64'd4);
    cycle();
    drive_p(1'b0, 5'd0, '0, '0);
    drive_c(1'b1, 5'd0, 64'd7, 64'd9);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_p_rvalid", DW'(p_rvalid), DW'(1));
      check("bp_p_rdata", p_rdata, 64'd6);
      check("bp_p_ready", DW'(p_ready), '0);
      check("bp_c_ready", DW'(c_ready), '0);
      cycle();
    end
    p_rready = 1'b1;
    #1;
    check("bp_release_c_ready", DW'(c_ready), DW'(1));
    check("bp_release_p_rdata", p_rdata, 64'd6);
    cycle();
    drive_c(1'b0, 5'd0, '0, '0);
    #1;
    check("bp_c_rvalid", DW'(c_rvalid), DW'(1));
    check("bp_c_rdata", c_rdata, 64'd16);
    cycle();

    // Back-to-back requests from C
    drive_c(1'b1, 5'd4, 64'hF0, 64'hFF);
    cycle();
    drive_c(1'b1, 5'd2, 64'hF0, 64'h3C);
    #1;
    check("b2b_first", c_rdata, 64'h0F);
    cycle();
    drive_c(1'b0, 5'd0, '0, '0);
    #1;
    check("b2b_second", c_rdata, 64'h30);
    cycle();

    // Reset mid-operation: P holds the slot while the starve counter is saturated
    for (int k = 0; k < 4; k++) begin
      drive_p(1'b1, 5'd0, rand_word(), rand_word());
      drive_c(1'b1, 5'd3, rand_word(), rand_word());
      cycle();
    end
    p_rready = 1'b0;
    #1;
    check("mid_p_rvalid", DW'(p_rvalid), DW'(1));
    check("mid_c_starved", DW'(c_starved), DW'(1));
    check("mid_blocked_p", DW'(p_ready), '0);
    check("mid_blocked_c", DW'(c_ready), '0);
    #2;
    rst = 1'b1;
    #1;
    check("async_p_rvalid", DW'(p_rvalid), '0);
    check("async_p_rdata", p_rdata, '0);
    check("async_c_starved", DW'(c_starved), '0);
    check("rst_ready_follows_valid", DW'(p_ready), DW'(1));
    p_exp_q.delete();
    c_exp_q.delete();
    @(posedge clk); #1;
    check("rst_no_accept", DW'(p_rvalid | c_rvalid), '0);
    rst = 1'b0;
    p_rready = 1'b1;
    drive_c(1'b0, 5'd0, '0, '0);
    drive_p(1'b1, 5'd1, 64'd100, 64'd23);
    #1;
    check("post_rst_p_ready", DW'(p_ready), DW'(1));
    cycle();
    drive_p(1'b0, 5'd0, '0, '0);
    #1;
    check("post_rst_p_rdata", p_rdata, 64'd77);
    cycle();

    // Random traffic checked against the reference arbiter
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    p_exp_q.delete();
    c_exp_q.delete();
    m_valid = 1'b0;
    m_owner = 1'b0;
    m_starve = 0;
    model_on = 1;
    for (int k = 0; k < 300; k++) begin
      drive_p(logic'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 4)),
              rand_word(), rand_word());
      drive_c(logic'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
              rand_word(), rand_word());
      p_rready = logic'($urandom_range(0, 3) != 0);
      c_rready = logic'($urandom_range(0, 3) != 0);
      cycle();
    end
    drive_p(1'b0, 5'd0, '0, '0);
    drive_c(1'b0, 5'd0, '0, '0);
    p_rready = 1'b1;
    c_rready = 1'b1;
    repeat (3) cycle();
    check("p_queue_empty", DW'(p_exp_q.size()), '0);
    check("c_queue_empty", DW'(c_exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
